// File: rtl/qpsk_pkg.sv
// Shared types and the QPSK symbol mapper for the baseband frame source.
package qpsk_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    PAYLOAD  = 2'd2,
    GAP      = 2'd3
  } state_t;

  typedef logic [1:0] sym_t;

  localparam int MAP_W = 32;

  typedef struct packed {
    logic signed [MAP_W-1:0] i;
    logic signed [MAP_W-1:0] q;
  } iq_t;

  // bit1 selects the I sign, bit0 the Q sign; a set bit maps to +amp.
  function automatic iq_t qpsk_map(input sym_t s, input int amp);
    iq_t r;
    r.i = s[1] ? amp : -amp;
    r.q = s[0] ? amp : -amp;
    return r;
  endfunction

endpackage

// File: rtl/qpsk_frame_gen_if.sv
// Output sample stream of the QPSK frame source: valid/ready handshake plus frame markers.
interface qpsk_frame_gen_if #(
  parameter int DATA_W = 16
);
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] I_out;
  logic signed [DATA_W-1:0] Q_out;
  logic                     sof;
  logic                     eof;

  modport master (
    output out_valid, I_out, Q_out, sof, eof,
    input  out_ready
  );

  modport slave (
    input  out_valid, I_out, Q_out, sof, eof,
    output out_ready
  );
endinterface

// File: rtl/qpsk_sym_buf.sv
// Payload symbol store: one synchronous write port, one asynchronous read port.
module qpsk_sym_buf
  import qpsk_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int RW    = 5
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  sym_t          wr_data,
  input  logic [RW-1:0] rd_addr,
  output sym_t          rd_data
);

  sym_t mem [DEPTH];

  // Out-of-range writes are dropped rather than aliased onto a valid entry.
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < (AW+1)'(DEPTH))) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = (rd_addr < RW'(DEPTH)) ? mem[rd_addr[AW-1:0]] : 2'b00;

endmodule

// File: rtl/qpsk_frame_gen.sv
// QPSK baseband frame source: preamble + payload symbols held for SPS samples,
// optional zero gap, repeated frames, valid/ready output with sof/eof markers.
module qpsk_frame_gen
  import qpsk_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int AMP          = 16384,
  parameter int SPS          = 16,
  parameter int PREAMBLE_LEN = 16,
  parameter int PAYLOAD_MAX  = 16,
  parameter int GAP_SAMPLES  = 0,
  parameter int REPEAT_W     = 8
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  start,
  input  logic                                                  abort,
  input  logic [2*PREAMBLE_LEN-1:0]                             preamble,
  input  logic [$clog2(PAYLOAD_MAX+1)-1:0]                      payload_len,
  input  logic [REPEAT_W-1:0]                                   repeat_cnt,
  input  logic                                                  pl_wr_en,
  input  logic [((PAYLOAD_MAX > 1) ? $clog2(PAYLOAD_MAX) : 1)-1:0] pl_wr_addr,
  input  logic [1:0]                                            pl_wr_data,
  qpsk_frame_gen_if.master                                      ob,
  output logic                                                  busy,
  output logic                                                  done
);

  localparam int LEN_W  = $clog2(PAYLOAD_MAX + 1);
  localparam int AW     = (PAYLOAD_MAX > 1) ? $clog2(PAYLOAD_MAX) : 1;
  localparam int MAXSYM = (PREAMBLE_LEN > PAYLOAD_MAX) ? PREAMBLE_LEN : PAYLOAD_MAX;
  localparam int SYM_W  = $clog2(MAXSYM + 1);
  localparam int SMP_W  = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int GAP_W  = (GAP_SAMPLES > 1) ? $clog2(GAP_SAMPLES) : 1;

  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SPS - 1);
  localparam logic [SYM_W-1:0] PRE_LAST = SYM_W'(PREAMBLE_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_SAMPLES > 0) ? GAP_SAMPLES - 1 : 0);

  state_t                   state, nstate;
  logic [SYM_W-1:0]         sym_cnt, nsym;
  logic [SMP_W-1:0]         sample_cnt, nsmp;
  logic [GAP_W-1:0]         gap_cnt, ngap;
  logic [REPEAT_W-1:0]      frames_left, nframes;
  logic                     ndone;

  logic [2*PREAMBLE_LEN-1:0] pre_q, cfg_pre, pre_shift;
  logic [LEN_W-1:0]          len_q, len_in, cfg_len;
  logic [REPEAT_W-1:0]       rep_in;

  logic                     valid_q, sof_q, eof_q;
  logic signed [DATA_W-1:0] i_q, q_q;
  logic signed [DATA_W-1:0] i_n, q_n;
  logic                     sof_n, eof_n;
  logic                     xfer, end_data, end_frame;
  sym_t                     pre_sym, buf_sym;
  iq_t                      iq;

  assign ob.out_valid = valid_q;
  assign ob.I_out     = i_q;
  assign ob.Q_out     = q_q;
  assign ob.sof       = sof_q;
  assign ob.eof       = eof_q;

  assign len_in  = (payload_len > LEN_W'(PAYLOAD_MAX)) ? LEN_W'(PAYLOAD_MAX) : payload_len;
  assign rep_in  = (repeat_cnt == '0) ? REPEAT_W'(1) : repeat_cnt;
  // In IDLE the configuration is being latched this edge, so look at the inputs directly.
  assign cfg_pre = (state == IDLE) ? preamble : pre_q;
  assign cfg_len = (state == IDLE) ? len_in : len_q;
  assign xfer    = valid_q & ob.out_ready;

  qpsk_sym_buf #(
    .DEPTH (PAYLOAD_MAX),
    .AW    (AW),
    .RW    (SYM_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (pl_wr_en & ~busy),
    .wr_addr (pl_wr_addr),
    .wr_data (pl_wr_data),
    .rd_addr (nsym),
    .rd_data (buf_sym)
  );

  // ---- next position: the counters describe the sample presented next cycle
  always_comb begin
    nstate    = state;
    nsym      = sym_cnt;
    nsmp      = sample_cnt;
    ngap      = gap_cnt;
    nframes   = frames_left;
    ndone     = 1'b0;
    end_data  = 1'b0;
    end_frame = 1'b0;

    if (abort) begin
      nstate  = IDLE;
      nsym    = '0;
      nsmp    = '0;
      ngap    = '0;
      nframes = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            nstate  = PREAMBLE;
            nsym    = '0;
            nsmp    = '0;
            ngap    = '0;
            nframes = rep_in;
          end
        end
        PREAMBLE: begin
          if (xfer) begin
            if (sample_cnt == SMP_LAST) begin
              nsmp = '0;
              if (sym_cnt == PRE_LAST) begin
                if (cfg_len == '0) begin
                  end_data = 1'b1;
                end else begin
                  nstate = PAYLOAD;
                  nsym   = '0;
                end
              end else begin
                nsym = sym_cnt + 1'b1;
              end
            end else begin
              nsmp = sample_cnt + 1'b1;
            end
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            if (sample_cnt == SMP_LAST) begin
              nsmp = '0;
              if (sym_cnt == SYM_W'(cfg_len) - SYM_W'(1)) begin
                end_data = 1'b1;
              end else begin
                nsym = sym_cnt + 1'b1;
              end
            end else begin
              nsmp = sample_cnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (xfer) begin
            if (gap_cnt == GAP_LAST) begin
              end_frame = 1'b1;
            end else begin
              ngap = gap_cnt + 1'b1;
            end
          end
        end
        default: nstate = IDLE;
      endcase

      if (end_data) begin
        if (GAP_SAMPLES > 0) begin
          nstate = GAP;
          nsym   = '0;
          ngap   = '0;
        end else begin
          end_frame = 1'b1;
        end
      end

      // Back-to-back frames restart the preamble with no idle bubble.
      if (end_frame) begin
        nsym = '0;
        nsmp = '0;
        ngap = '0;
        if (frames_left > REPEAT_W'(1)) begin
          nframes = frames_left - 1'b1;
          nstate  = PREAMBLE;
        end else begin
          nframes = '0;
          nstate  = IDLE;
          ndone   = 1'b1;
        end
      end
    end
  end

  // ---- sample values and markers for the next position
  always_comb begin
    pre_shift = cfg_pre << {nsym, 1'b0};
    pre_sym   = pre_shift[2*PREAMBLE_LEN-1 -: 2];
    iq        = '0;
    case (nstate)
      PREAMBLE: iq = qpsk_map(pre_sym, AMP);
      PAYLOAD:  iq = qpsk_map(buf_sym, AMP);
      default:  iq = '0;
    endcase
    i_n   = DATA_W'(iq.i);
    q_n   = DATA_W'(iq.q);
    sof_n = (nstate == PREAMBLE) && (nsym == '0) && (nsmp == '0);
    eof_n = (nsmp == SMP_LAST) &&
            (((nstate == PREAMBLE) && (nsym == PRE_LAST) && (cfg_len == '0)) ||
             ((nstate == PAYLOAD) && (nsym == SYM_W'(cfg_len) - SYM_W'(1))));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sym_cnt     <= '0;
      sample_cnt  <= '0;
      gap_cnt     <= '0;
      frames_left <= '0;
      valid_q     <= 1'b0;
      i_q         <= '0;
      q_q         <= '0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= nstate;
      sym_cnt     <= nsym;
      sample_cnt  <= nsmp;
      gap_cnt     <= ngap;
      frames_left <= nframes;
      valid_q     <= (nstate != IDLE);
      i_q         <= i_n;
      q_q         <= q_n;
      sof_q       <= sof_n;
      eof_q       <= eof_n;
      busy        <= (nstate != IDLE);
      done        <= ndone;
    end
  end

  always_ff @(posedge clk) begin
    if ((state == IDLE) && start && !abort) begin
      pre_q <= preamble;
      len_q <= len_in;
    end
  end

endmodule

// File: tb/tb_qpsk_frame_gen.sv
// Directed scoreboard bench for qpsk_frame_gen (gap=2 instance plus a gap=0 instance).
module tb_qpsk_frame_gen;

  localparam int DW  = 16;
  localparam int AMP = 16384;
  localparam int SPS = 4;
  localparam int PL  = 4;

  typedef struct {
    logic signed [DW-1:0] i;
    logic signed [DW-1:0] q;
    logic                 sof;
    logic                 eof;
  } samp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, start_z = 1'b0, abort = 1'b0;
  logic [7:0] preamble = '0;
  logic [2:0] payload_len = '0;
  logic [7:0] repeat_cnt = '0;
  logic       pl_wr_en = 1'b0;
  logic [1:0] pl_wr_addr = '0, pl_wr_data = '0;
  logic       rdy = 1'b1;
  logic       busy_g, done_g, busy_z, done_z;
  bit         sel = 1'b0;

  int    checks = 0;
  int    failures = 0;
  samp_t sb[$];
  logic [1:0] pl_model [4];

  always #5 clk = ~clk;

  qpsk_frame_gen_if #(.DATA_W(DW)) obg ();
  qpsk_frame_gen_if #(.DATA_W(DW)) obz ();
  assign obg.out_ready = rdy;
  assign obz.out_ready = rdy;

  qpsk_frame_gen #(.DATA_W(DW), .AMP(AMP), .SPS(SPS), .PREAMBLE_LEN(PL), .PAYLOAD_MAX(4),
                   .GAP_SAMPLES(2), .REPEAT_W(8)) dut_g (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .preamble(preamble),
    .payload_len(payload_len), .repeat_cnt(repeat_cnt), .pl_wr_en(pl_wr_en),
    .pl_wr_addr(pl_wr_addr), .pl_wr_data(pl_wr_data), .ob(obg), .busy(busy_g), .done(done_g));

  qpsk_frame_gen #(.DATA_W(DW), .AMP(AMP), .SPS(SPS), .PREAMBLE_LEN(PL), .PAYLOAD_MAX(4),
                   .GAP_SAMPLES(0), .REPEAT_W(8)) dut_z (
    .clk(clk), .rst(rst), .start(start_z), .abort(abort), .preamble(preamble),
    .payload_len(payload_len), .repeat_cnt(repeat_cnt), .pl_wr_en(pl_wr_en),
    .pl_wr_addr(pl_wr_addr), .pl_wr_data(pl_wr_data), .ob(obz), .busy(busy_z), .done(done_z));

  logic                 o_valid, o_sof, o_eof, o_busy, o_done;
  logic signed [DW-1:0] o_i, o_q;
  assign o_valid = sel ? obz.out_valid : obg.out_valid;
  assign o_sof   = sel ? obz.sof       : obg.sof;
  assign o_eof   = sel ? obz.eof       : obg.eof;
  assign o_i     = sel ? obz.I_out     : obg.I_out;
  assign o_q     = sel ? obz.Q_out     : obg.Q_out;
  assign o_busy  = sel ? busy_z        : busy_g;
  assign o_done  = sel ? done_z        : done_g;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [DW-1:0] lvl(input logic b);
    return b ? DW'(AMP) : -DW'(AMP);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [1:0] d);
    pl_wr_addr = a;
    pl_wr_data = d;
    pl_wr_en   = 1'b1;
    cyc();
    pl_wr_en   = 1'b0;
    pl_model[a] = d;
  endtask

  task automatic push_expected(input logic [7:0] pre, input int len, input int rep, input int gap);
    int    nfr;
    samp_t s;
    logic [1:0] sym;
    nfr = (rep == 0) ? 1 : rep;
    for (int f = 0; f < nfr; f++) begin
      for (int k = 0; k < PL; k++) begin
        sym = pre[2*(PL-1-k) +: 2];
        for (int j = 0; j < SPS; j++) begin
          s.i = lvl(sym[1]); s.q = lvl(sym[0]);
          s.sof = (k == 0) && (j == 0);
          s.eof = (len == 0) && (k == PL-1) && (j == SPS-1);
          sb.push_back(s);
        end
      end
      for (int k = 0; k < len; k++) begin
        sym = pl_model[k];
        for (int j = 0; j < SPS; j++) begin
          s.i = lvl(sym[1]); s.q = lvl(sym[0]);
          s.sof = 1'b0;
          s.eof = (k == len-1) && (j == SPS-1);
          sb.push_back(s);
        end
      end
      for (int g = 0; g < gap; g++) begin
        s.i = '0; s.q = '0; s.sof = 1'b0; s.eof = 1'b0;
        sb.push_back(s);
      end
    end
  endtask

  task automatic go(input logic [7:0] pre, input logic [2:0] len, input logic [7:0] rep, input bit z);
    preamble = pre; payload_len = len; repeat_cnt = rep; rdy = 1'b1;
    if (z) start_z = 1'b1; else start = 1'b1;
    cyc();
    start = 1'b0; start_z = 1'b0;
  endtask

  // Drains the scoreboard against the selected DUT; inject_at >= 0 fires an ignored start+write.
  task automatic run_stream(input string nm, input bit rand_rdy, input int inject_at, input int exp_n);
    int    n = 0, cnt = 0, bubbles = 0, early_done = 0;
    bit    stalled = 1'b0;
    samp_t held, e;
    while (sb.size() > 0 && cnt < 2000) begin
      @(negedge clk);
      if (o_done) early_done++;
      if (stalled) begin
        chk($sformatf("%s hold_valid", nm), o_valid, 1'b1);
        chk($sformatf("%s hold_I", nm), o_i, held.i);
        chk($sformatf("%s hold_Q", nm), o_q, held.q);
        chk($sformatf("%s hold_sof", nm), o_sof, held.sof);
        chk($sformatf("%s hold_eof", nm), o_eof, held.eof);
      end
      if (o_valid && rdy) begin
        e = sb.pop_front();
        chk($sformatf("%s I[%0d]", nm, n), o_i, e.i);
        chk($sformatf("%s Q[%0d]", nm, n), o_q, e.q);
        chk($sformatf("%s sof[%0d]", nm, n), o_sof, e.sof);
        chk($sformatf("%s eof[%0d]", nm, n), o_eof, e.eof);
        n++;
      end else if (!o_valid) begin
        bubbles++;
      end
      stalled = o_valid && !rdy;
      held.i = o_i; held.q = o_q; held.sof = o_sof; held.eof = o_eof;
      @(posedge clk);
      #1;
      start = 1'b0; pl_wr_en = 1'b0;
      if (cnt == inject_at) begin
        start = 1'b1; preamble = 8'hFF; payload_len = 3'd1;
        pl_wr_en = 1'b1; pl_wr_addr = 2'd0; pl_wr_data = ~pl_model[0];
      end
      rdy = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
      cnt++;
    end
    start = 1'b0; pl_wr_en = 1'b0;
    chk($sformatf("%s leftover", nm), sb.size(), 0);
    chk($sformatf("%s count", nm), n, exp_n);
    chk($sformatf("%s early_done", nm), early_done, 0);
    if (!rand_rdy) chk($sformatf("%s bubbles", nm), bubbles, 0);
    @(negedge clk);
    chk($sformatf("%s done_pulse", nm), o_done, 1'b1);
    chk($sformatf("%s valid_after", nm), o_valid, 1'b0);
    chk($sformatf("%s busy_after", nm), o_busy, 1'b0);
    @(negedge clk);
    chk($sformatf("%s done_once", nm), o_done, 1'b0);
  endtask

  initial begin
    // reset state
    #12;
    chk("rst valid", obg.out_valid, 1'b0);
    chk("rst I", obg.I_out, '0);
    chk("rst busy", busy_g, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle valid_g", obg.out_valid, 1'b0);
    chk("idle sof_g", obg.sof, 1'b0);
    chk("idle eof_g", obg.eof, 1'b0);
    chk("idle done_g", done_g, 1'b0);
    chk("idle Q_g", obg.Q_out, '0);
    chk("idle valid_z", obz.out_valid, 1'b0);
    chk("idle busy_z", busy_z, 1'b0);
    wr(2'd0, 2'b11);
    wr(2'd1, 2'b00);
    wr(2'd2, 2'b10);
    wr(2'd3, 2'b01);

    // test 1: single frame with gap
    push_expected(8'b00_01_10_11, 2, 1, 2);
    go(8'b00_01_10_11, 3'd2, 8'd1, 1'b0);
    run_stream("t1", 1'b0, -1, 26);

    // test 2: three back-to-back frames
    push_expected(8'b00_01_10_11, 2, 3, 2);
    go(8'b00_01_10_11, 3'd2, 8'd3, 1'b0);
    run_stream("t2", 1'b0, -1, 78);

    // test 3: random backpressure
    push_expected(8'b00_01_10_11, 2, 1, 2);
    go(8'b00_01_10_11, 3'd2, 8'd1, 1'b0);
    run_stream("t3", 1'b1, -1, 26);

    // test 4: preamble-only frame, repeat 0, no gap
    sel = 1'b1;
    push_expected(8'b00_01_10_11, 0, 0, 0);
    go(8'b00_01_10_11, 3'd0, 8'd0, 1'b1);
    run_stream("t4", 1'b0, -1, 16);
    sel = 1'b0;

    // test 5: abort at sample 10, then abort+start together, then clean restart
    go(8'b00_01_10_11, 3'd2, 8'd1, 1'b0);
    repeat (10) cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    @(negedge clk);
    chk("abort valid", obg.out_valid, 1'b0);
    chk("abort busy", busy_g, 1'b0);
    chk("abort I", obg.I_out, '0);
    chk("abort Q", obg.Q_out, '0);
    chk("abort done", done_g, 1'b0);
    @(negedge clk);
    chk("abort no_done", done_g, 1'b0);
    start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("abort_prio busy", busy_g, 1'b0);
    chk("abort_prio valid", obg.out_valid, 1'b0);
    push_expected(8'b00_01_10_11, 2, 1, 2);
    go(8'b00_01_10_11, 3'd2, 8'd1, 1'b0);
    run_stream("t5", 1'b0, -1, 26);

    // test 6: start and buffer write while busy are ignored
    push_expected(8'b00_01_10_11, 2, 1, 2);
    go(8'b00_01_10_11, 3'd2, 8'd1, 1'b0);
    run_stream("t6", 1'b0, 3, 26);

    // test 6b: asynchronous reset mid-frame, then restart
    go(8'b00_01_10_11, 3'd2, 8'd1, 1'b0);
    repeat (5) cyc();
    #2 rst = 1'b1;
    #1;
    chk("rst_mid valid", obg.out_valid, 1'b0);
    chk("rst_mid I", obg.I_out, '0);
    chk("rst_mid Q", obg.Q_out, '0);
    chk("rst_mid sof", obg.sof, 1'b0);
    chk("rst_mid busy", busy_g, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid no_resume", obg.out_valid, 1'b0);
    push_expected(8'b00_01_10_11, 2, 1, 2);
    go(8'b00_01_10_11, 3'd2, 8'd1, 1'b0);
    run_stream("t6b", 1'b0, -1, 26);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
